// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port; one transaction
// outstanding, round-robin on ties, WAIT-state timeout returning zero data.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_resp_data,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,

    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            last_lsu_q, last_lsu_d;    // 1: LSU was granted most recently
    logic            owner_lsu_q, owner_lsu_d;
    logic [63:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            ifu_win;
    logic            lsu_win;

    always_comb begin
        ifu_win = ifu_req_valid & (~lsu_req_valid | last_lsu_q);
        lsu_win = lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);
    end

    always_comb begin
        state_d       = state_q;
        last_lsu_d    = last_lsu_q;
        owner_lsu_d   = owner_lsu_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                ifu_req_ready = ifu_win;
                lsu_req_ready = lsu_win;
                if (ifu_win) begin
                    owner_lsu_d = 1'b0;
                    last_lsu_d  = 1'b0;
                    addr_d      = ifu_req_addr;
                    we_d        = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    state_d     = S_ISSUE;
                end else if (lsu_win) begin
                    owner_lsu_d = 1'b1;
                    last_lsu_d  = 1'b1;
                    addr_d      = lsu_req_addr;
                    we_d        = lsu_req_we;
                    wdata_d     = lsu_req_wdata;
                    wmask_d     = lsu_req_wmask;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the final counted cycle beats the timeout
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_lsu_q  <= 1'b1;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req_valid  = (state_q == S_ISSUE);
    assign mem_req_addr   = addr_q;
    assign mem_req_we     = we_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;

    assign ifu_resp_valid = (state_q == S_RESP) & ~owner_lsu_q;
    assign lsu_resp_valid = (state_q == S_RESP) &  owner_lsu_q;
    assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
    assign lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;

    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = (state_q == S_RESP) & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_resp_valid;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [7:0]  mem_req_wmask;
    logic        busy, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Transaction-level model: one in-flight transaction with progress flags
    bit          m_active, m_acked, m_done, m_owner_lsu, m_last_lsu, m_we, m_err;
    logic [63:0] m_addr, m_wdata, m_data;
    logic [7:0]  m_wmask;
    int unsigned m_wait_n;
    int unsigned ifu_miss, lsu_miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ifu_win();
        return !m_active && ifu_req_valid && (!lsu_req_valid || m_last_lsu);
    endfunction

    function automatic bit m_lsu_win();
        return !m_active && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
    endfunction

    task automatic check_all();
        bit rv;
        rv = m_active && m_done;
        chk("ifu_req_ready", ifu_req_ready, m_ifu_win());
        chk("lsu_req_ready", lsu_req_ready, m_lsu_win());
        chk("mem_req_valid", mem_req_valid, m_active && !m_acked);
        chk("mem_req_addr", mem_req_addr, m_addr);
        chk("mem_req_we", mem_req_we, m_we);
        chk("mem_req_wdata", mem_req_wdata, m_wdata);
        chk("mem_req_wmask", mem_req_wmask, m_wmask);
        chk("ifu_resp_valid", ifu_resp_valid, rv && !m_owner_lsu);
        chk("ifu_resp_data", ifu_resp_data, (rv && !m_owner_lsu) ? m_data : 64'h0);
        chk("lsu_resp_valid", lsu_resp_valid, rv && m_owner_lsu);
        chk("lsu_resp_data", lsu_resp_data, (rv && m_owner_lsu) ? m_data : 64'h0);
        chk("busy", busy, m_active);
        chk("timeout_err", timeout_err, rv && m_err);
    endtask

    // A requester holding valid may lose at most one IDLE arbitration in a row
    task automatic check_fair();
        if (rst || !ifu_req_valid || ifu_req_ready) ifu_miss = 0;
        else if (!m_active) begin
            ifu_miss++;
            chk("ifu_fairness", 64'(ifu_miss <= 1), 64'h1);
        end
        if (rst || !lsu_req_valid || lsu_req_ready) lsu_miss = 0;
        else if (!m_active) begin
            lsu_miss++;
            chk("lsu_fairness", 64'(lsu_miss <= 1), 64'h1);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_active = 0; m_acked = 0; m_done = 0; m_owner_lsu = 0; m_last_lsu = 1;
            m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_data = '0; m_wmask = '0;
            m_wait_n = 0;
        end else if (!m_active) begin
            if (m_ifu_win()) begin
                m_active = 1; m_owner_lsu = 0; m_last_lsu = 0;
                m_addr = ifu_req_addr; m_we = 0; m_wdata = '0; m_wmask = '0;
            end else if (m_lsu_win()) begin
                m_active = 1; m_owner_lsu = 1; m_last_lsu = 1;
                m_addr = lsu_req_addr; m_we = lsu_req_we; m_wdata = lsu_req_wdata;
                m_wmask = lsu_req_wmask;
            end
        end else if (!m_acked) begin
            if (mem_req_ready) begin
                m_acked = 1; m_wait_n = 0;
            end
        end else if (!m_done) begin
            if (mem_resp_valid) begin
                m_done = 1; m_data = mem_resp_data; m_err = 0;
            end else if (m_wait_n + 1 == TO) begin
                m_done = 1; m_data = '0; m_err = 1;
            end else begin
                m_wait_n++;
            end
        end else begin
            m_active = 0; m_acked = 0; m_done = 0;
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        check_fair();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_req_addr = '0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_we = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    initial begin
        ifu_miss = 0; lsu_miss = 0;
        rst = 1;
        idle_inputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1 chk("reset_busy", busy, 64'h0);
        chk("reset_mem_req_valid", mem_req_valid, 64'h0);
        tick();
        rst = 0;

        // Stray memory response while idle
        mem_resp_valid = 1; mem_resp_data = 64'hDEAD;
        tick();
        mem_resp_valid = 0;
        #1 chk("stray_busy", busy, 64'h0);
        chk("stray_ifu_resp", ifu_resp_valid, 64'h0);
        chk("stray_lsu_resp", lsu_resp_valid, 64'h0);
        tick();

        // Ties from reset: IFU, then LSU, then IFU
        ifu_req_valid = 1; ifu_req_addr = 64'h8000_0004;
        lsu_req_valid = 1; lsu_req_addr = 64'h8000_1000;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 64'h1111;
        #1 chk("tie1_ifu_ready", ifu_req_ready, 64'h1);
        chk("tie1_lsu_ready", lsu_req_ready, 64'h0);
        tick();
        #1 chk("tie1_addr", mem_req_addr, 64'h8000_0004);
        tick(); tick();
        #1 chk("tie1_ifu_resp", ifu_resp_valid, 64'h1);
        tick();
        #1 chk("tie2_lsu_ready", lsu_req_ready, 64'h1);
        chk("tie2_ifu_ready", ifu_req_ready, 64'h0);
        tick();
        #1 chk("tie2_addr", mem_req_addr, 64'h8000_1000);
        tick(); tick();
        #1 chk("tie2_lsu_resp", lsu_resp_valid, 64'h1);
        tick();
        #1 chk("tie3_ifu_ready", ifu_req_ready, 64'h1);
        tick();
        idle_inputs();
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 64'h2222;
        repeat (3) tick();

        // Basic IFU fetch at minimum latency
        idle_inputs();
        ifu_req_valid = 1; ifu_req_addr = 64'h8000_0000; mem_req_ready = 1;
        #1 chk("fetch_ready", ifu_req_ready, 64'h1);
        tick();
        ifu_req_valid = 0;
        #1 chk("fetch_mem_valid", mem_req_valid, 64'h1);
        chk("fetch_mem_addr", mem_req_addr, 64'h8000_0000);
        tick();
        mem_resp_valid = 1; mem_resp_data = 64'h0010_0073_0000_0413;
        tick();
        mem_resp_valid = 0;
        #1 chk("fetch_resp_valid", ifu_resp_valid, 64'h1);
        chk("fetch_resp_data", ifu_resp_data, 64'h0010_0073_0000_0413);
        chk("fetch_lsu_quiet", lsu_resp_valid, 64'h0);
        tick();
        #1 chk("fetch_done_busy", busy, 64'h0);

        // LSU store with memory stalling three cycles
        idle_inputs();
        lsu_req_valid = 1; lsu_req_addr = 64'h8000_1000; lsu_req_we = 1;
        lsu_req_wdata = 64'h8765_4321_1234_5678; lsu_req_wmask = 8'hAA;
        #1 chk("store_ready", lsu_req_ready, 64'h1);
        tick();
        idle_inputs();
        for (int unsigned i = 0; i < 3; i++) begin
            #1 chk("store_stall_valid", mem_req_valid, 64'h1);
            chk("store_stall_addr", mem_req_addr, 64'h8000_1000);
            chk("store_stall_we", mem_req_we, 64'h1);
            chk("store_stall_wdata", mem_req_wdata, 64'h8765_4321_1234_5678);
            chk("store_stall_wmask", mem_req_wmask, 64'hAA);
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'hACCE55;
        tick();
        mem_resp_valid = 0;
        #1 chk("store_resp_valid", lsu_resp_valid, 64'h1);
        chk("store_resp_data", lsu_resp_data, 64'hACCE55);
        chk("store_ifu_quiet", ifu_resp_valid, 64'h0);
        tick();
        #1 chk("store_single_pulse", lsu_resp_valid, 64'h0);

        // Timeout with no response, then response on the final cycle
        for (int unsigned k = 0; k < 2; k++) begin
            idle_inputs();
            ifu_req_valid = 1; ifu_req_addr = 64'h8000_0040; mem_req_ready = 1;
            tick();
            ifu_req_valid = 0;
            tick();
            repeat (TO - 1) tick();
            if (k == 1) begin
                mem_resp_valid = 1; mem_resp_data = 64'hBEEF;
            end
            #1 chk("to_no_early_pulse", ifu_resp_valid, 64'h0);
            tick();
            mem_resp_valid = 0;
            #1 chk("to_resp_valid", ifu_resp_valid, 64'h1);
            chk("to_resp_data", ifu_resp_data, (k == 1) ? 64'hBEEF : 64'h0);
            chk("to_err", timeout_err, (k == 1) ? 64'h0 : 64'h1);
            tick();
            #1 chk("to_idle", busy, 64'h0);
            chk("to_err_clear", timeout_err, 64'h0);
        end

        // Reset during WAIT, stale response, then a clean fetch
        idle_inputs();
        ifu_req_valid = 1; ifu_req_addr = 64'h8000_0100; mem_req_ready = 1;
        tick();
        ifu_req_valid = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; mem_resp_valid = 1; mem_resp_data = 64'hDEAD;
        #1 chk("rst_busy", busy, 64'h0);
        tick();
        mem_resp_valid = 0;
        #1 chk("rst_no_resp", ifu_resp_valid, 64'h0);
        chk("rst_no_req", mem_req_valid, 64'h0);
        tick();
        ifu_req_valid = 1; ifu_req_addr = 64'h8000_0200;
        #1 chk("post_rst_ready", ifu_req_ready, 64'h1);
        tick();
        ifu_req_valid = 0;
        tick();
        mem_resp_valid = 1; mem_resp_data = 64'h1234;
        tick();
        mem_resp_valid = 0;
        #1 chk("post_rst_resp", ifu_resp_data, 64'h1234);
        tick();

        // Randomized traffic with sticky requesters
        for (int unsigned c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            ifu_req_valid = ifu_req_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            lsu_req_valid = lsu_req_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            ifu_req_addr  = {$urandom, $urandom};
            lsu_req_addr  = {$urandom, $urandom};
            lsu_req_we    = $urandom_range(0, 1) == 1;
            lsu_req_wdata = {$urandom, $urandom};
            lsu_req_wmask = 8'($urandom);
            mem_req_ready = $urandom_range(0, 99) < 60;
            mem_resp_valid = $urandom_range(0, 99) < 25;
            mem_resp_data = {$urandom, $urandom};
            tick();
        end

        rst = 0;
        idle_inputs();
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
